// File: rtl/axi_pkg.sv
// Shared AXI4 constants, helpers and the burst reader state type.
package axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam int         BOUNDARY_4K   = 4096;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} reader_state_t;

  function automatic logic [2:0] size_of(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign count    = count_q;

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a block read into 4 KB-safe INCR bursts and
// streams the returned words out through a decoupling FIFO.
module axi_burst_reader
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clock,
  input  logic              aresetn,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_base,
  input  logic [LEN_W-1:0]  io_len,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_err,
  output logic              io_axi_ar_valid,
  input  logic              io_axi_ar_ready,
  output logic [ADDR_W-1:0] io_axi_ar_bits_addr,
  output logic [7:0]        io_axi_ar_bits_len,
  output logic [2:0]        io_axi_ar_bits_size,
  output logic [1:0]        io_axi_ar_bits_burst,
  output logic [3:0]        io_axi_ar_bits_cache,
  output logic [2:0]        io_axi_ar_bits_prot,
  output logic              io_axi_ar_bits_lock,
  output logic [3:0]        io_axi_ar_bits_qos,
  output logic [3:0]        io_axi_ar_bits_region,
  input  logic              io_axi_r_valid,
  output logic              io_axi_r_ready,
  input  logic [DATA_W-1:0] io_axi_r_bits_data,
  input  logic [1:0]        io_axi_r_bits_resp,
  input  logic              io_axi_r_bits_last,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_bits
);

  localparam logic [2:0] SIZE = size_of(DATA_W);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CMPW = (CW > 9) ? CW : 9;

  reader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [8:0]        beat_cnt_q;
  logic              busy_q, done_q, err_q;

  logic [12:0]       to_4k;
  logic [8:0]        cand;
  logic [8:0]        beats;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     free_slots;
  logic              fifo_empty, fifo_full;
  logic              ar_hs, r_hs, pop;

  // Burst size: limited by what is left, MAX_BURST, and the distance to the next 4 KB page.
  always_comb begin
    to_4k = (13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> SIZE;
    if (remaining_q > LEN_W'(MAX_BURST)) cand = 9'(MAX_BURST);
    else                                 cand = remaining_q[8:0];
    if (to_4k < {4'b0000, cand}) beats = to_4k[8:0];
    else                         beats = cand;
  end

  assign free_slots = CW'(FIFO_DEPTH) - fifo_count;

  always_comb begin
    state_d         = state_q;
    io_axi_ar_valid = 1'b0;
    io_axi_r_ready  = 1'b0;
    case (state_q)
      IDLE: if (io_start && io_len != '0) state_d = ADDR;
      ADDR: begin
        // Free space only grows while waiting here, so ar_valid cannot drop before ar_ready.
        io_axi_ar_valid = (CMPW'(free_slots) >= CMPW'(beats));
        if (io_axi_ar_valid && io_axi_ar_ready) state_d = DATA;
      end
      DATA: begin
        io_axi_r_ready = !fifo_full;
        if (r_hs && beat_cnt_q == 9'd1) state_d = (remaining_q != '0) ? ADDR : DRAIN;
      end
      DRAIN: if (pop && fifo_count == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ar_hs = io_axi_ar_valid && io_axi_ar_ready;
  assign r_hs  = io_axi_r_valid && io_axi_r_ready;
  assign pop   = io_out_valid && io_out_ready;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (io_start) begin
          err_q       <= 1'b0;
          addr_q      <= io_base;
          remaining_q <= io_len;
          if (io_len == '0) done_q <= 1'b1;
          else              busy_q <= 1'b1;
        end
        ADDR: if (ar_hs) begin
          addr_q      <= addr_q + (ADDR_W'(beats) << SIZE);
          remaining_q <= remaining_q - LEN_W'(beats);
          beat_cnt_q  <= beats;
        end
        DATA: if (r_hs) begin
          beat_cnt_q <= beat_cnt_q - 9'd1;
          if (io_axi_r_bits_resp != RESP_OKAY ||
              io_axi_r_bits_last != (beat_cnt_q == 9'd1))
            err_q <= 1'b1;
        end
        DRAIN: if (pop && fifo_count == CW'(1)) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .aresetn   (aresetn),
    .push      (r_hs),
    .push_data (io_axi_r_bits_data),
    .pop       (pop),
    .pop_data  (io_out_bits),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign io_out_valid          = !fifo_empty;
  assign io_busy               = busy_q;
  assign io_done               = done_q;
  assign io_err                = err_q;
  assign io_axi_ar_bits_addr   = addr_q;
  assign io_axi_ar_bits_len    = 8'(beats - 9'd1);
  assign io_axi_ar_bits_size   = SIZE;
  assign io_axi_ar_bits_burst  = BURST_INCR;
  assign io_axi_ar_bits_cache  = CACHE_DEFAULT;
  assign io_axi_ar_bits_prot   = 3'b000;
  assign io_axi_ar_bits_lock   = 1'b0;
  assign io_axi_ar_bits_qos    = 4'b0000;
  assign io_axi_ar_bits_region = 4'b0000;

endmodule
